fb_read_arbiter: RTL and testbench

Shares the 65 MHz read port (port B) of the camera frame buffer between the VGA fetch path and one auxiliary requester, such as hand/head tracking sampling or a debug readback. Video reads are hard real-time: every video request is issued on the cycle it arrives and returns at the fixed BRAM latency. Auxiliary reads use a one-entry holding register and are slotted into cycles with no video request, typically blanking. Returned data is steered by a tag pipeline that matches the BRAM read latency.

---
 rtl/fb_read_arbiter_if.sv | 54 +++++
 rtl/fb_read_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_fb_read_arbiter.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/fb_read_arbiter_if.sv
// -----------------------------------------------------------------------------
// fb_read_arbiter_if
// Bus bundle between the frame-buffer read arbiter and its surroundings:
// the video fetch requester, the auxiliary requester, the BRAM read port B
// and the statistics counters.
//
// Modports:
//   slave  - the arbiter side (takes requests and BRAM data, drives results)
//   master - the environment side (drives requests and BRAM data)
//
// Signals:
//   vid_req_in / vid_addr_in       video read request and address
//   vid_data_out / vid_valid_out   video read data and its valid
//   aux_req_in / aux_addr_in       auxiliary read request and address
//   aux_ready_out                  auxiliary holding register empty
//   aux_data_out / aux_valid_out   last auxiliary data and its update pulse
//   starve_out                     pending aux request has waited too long
//   mem_addr_out / mem_data_in     BRAM addrb / doutb
//   aux_grants_out                 aux reads issued
//   vid_conflicts_out              cycles with aux pending behind video
// -----------------------------------------------------------------------------
interface fb_read_arbiter_if #(
  parameter int ADDR_WIDTH = 17,
  parameter int DATA_WIDTH = 16
);
  logic                  vid_req_in;
  logic [ADDR_WIDTH-1:0] vid_addr_in;
  logic [DATA_WIDTH-1:0] vid_data_out;
  logic                  vid_valid_out;
  logic                  aux_req_in;
  logic [ADDR_WIDTH-1:0] aux_addr_in;
  logic                  aux_ready_out;
  logic [DATA_WIDTH-1:0] aux_data_out;
  logic                  aux_valid_out;
  logic                  starve_out;
  logic [ADDR_WIDTH-1:0] mem_addr_out;
  logic [DATA_WIDTH-1:0] mem_data_in;
  logic [15:0]           aux_grants_out;
  logic [15:0]           vid_conflicts_out;

  modport slave (
    input  vid_req_in, vid_addr_in, aux_req_in, aux_addr_in, mem_data_in,
    output vid_data_out, vid_valid_out, aux_ready_out, aux_data_out,
           aux_valid_out, starve_out, mem_addr_out, aux_grants_out,
           vid_conflicts_out
  );

  modport master (
    output vid_req_in, vid_addr_in, aux_req_in, aux_addr_in, mem_data_in,
    input  vid_data_out, vid_valid_out, aux_ready_out, aux_data_out,
           aux_valid_out, starve_out, mem_addr_out, aux_grants_out,
           vid_conflicts_out
  );
endinterface

// File: rtl/fb_read_arbiter.sv
// -----------------------------------------------------------------------------
// fb_read_arbiter
// Shares the frame buffer read port B between the hard real-time VGA fetch
// path and one auxiliary requester. Video requests always own the port in the
// cycle they arrive. An auxiliary request is parked in a one-entry holding
// register and issued in the first cycle without a video request. A tag
// pipeline as deep as the BRAM read latency steers returning data.
//
// Ports:
//   clk_in  - 65 MHz pixel clock (single clock domain)
//   rst_in  - asynchronous active-low reset
//   bus     - fb_read_arbiter_if.slave (requests, BRAM port, results, stats)
//
// Parameters:
//   ADDR_WIDTH   - frame buffer address width
//   DATA_WIDTH   - pixel width
//   LATENCY      - BRAM read latency in cycles (>= 1)
//   STARVE_LIMIT - wait cycles after which starve_out asserts (>= 1)
//
// Build option:
//   FB_ARB_STATS_EN - when defined, builds 16-bit saturating counters for
//                     aux grants and video conflict cycles; when undefined
//                     both statistics outputs are tied to zero.
// -----------------------------------------------------------------------------
module fb_read_arbiter #(
  parameter int ADDR_WIDTH   = 17,
  parameter int DATA_WIDTH   = 16,
  parameter int LATENCY      = 2,
  parameter int STARVE_LIMIT = 64
) (
  input  logic              clk_in,
  input  logic              rst_in,
  fb_read_arbiter_if.slave  bus
);

  localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [WAIT_W-1:0] STARVE_LIMIT_C = WAIT_W'(STARVE_LIMIT);

  // Holding register occupancy
  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_PEND  = 1'b1
  } hold_state_t;

  hold_state_t           state_r;
  hold_state_t           state_s;
  logic                  accept_s;
  logic                  issue_s;
  logic                  conflict_s;
  logic [ADDR_WIDTH-1:0] pend_addr_r;

  logic [LATENCY-1:0]    vid_tag_r;
  logic [LATENCY-1:0]    aux_tag_r;

  logic [DATA_WIDTH-1:0] aux_data_r;
  logic                  aux_valid_r;
  logic [WAIT_W-1:0]     wait_cnt_r;

  // Holding register state update
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_r <= ST_EMPTY;
    end else begin
      state_r <= state_s;
    end
  end

  // Accept/issue decisions; video always wins the port, so a pending aux
  // read only goes out in a cycle with no video request.
  always_comb begin
    state_s    = state_r;
    accept_s   = 1'b0;
    issue_s    = 1'b0;
    conflict_s = 1'b0;
    case (state_r)
      ST_EMPTY: begin
        if (bus.aux_req_in) begin
          accept_s = 1'b1;
          state_s  = ST_PEND;
        end else begin
          state_s  = ST_EMPTY;
        end
      end
      ST_PEND: begin
        if (!bus.vid_req_in) begin
          issue_s    = 1'b1;
          state_s    = ST_EMPTY;
        end else begin
          conflict_s = 1'b1;
          state_s    = ST_PEND;
        end
      end
      default: begin
        state_s = ST_EMPTY;
      end
    endcase
  end

  // Capture the aux address on acceptance; it stays on the mux input until
  // the next acceptance, which keeps mem_addr_out stable in idle cycles.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      pend_addr_r <= {ADDR_WIDTH{1'b0}};
    end else if (accept_s) begin
      pend_addr_r <= bus.aux_addr_in;
    end else begin
      pend_addr_r <= pend_addr_r;
    end
  end

  // Port B address: video passes straight through with no added latency.
  assign bus.mem_addr_out  = bus.vid_req_in ? bus.vid_addr_in : pend_addr_r;
  assign bus.aux_ready_out = (state_r == ST_EMPTY);

  // Tag pipeline shifted every cycle; stage 0 holds what was issued in the
  // previous cycle, so the last stage lines up with the BRAM output.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      vid_tag_r <= {LATENCY{1'b0}};
      aux_tag_r <= {LATENCY{1'b0}};
    end else begin
      vid_tag_r[0] <= bus.vid_req_in;
      aux_tag_r[0] <= issue_s;
      for (int i = 1; i < LATENCY; i++) begin
        vid_tag_r[i] <= vid_tag_r[i-1];
        aux_tag_r[i] <= aux_tag_r[i-1];
      end
    end
  end

  assign bus.vid_valid_out = vid_tag_r[LATENCY-1];
  assign bus.vid_data_out  = bus.mem_data_in;

  // Aux return: register the BRAM word when the aux tag reaches the end,
  // so the requester sees stable data one cycle after the BRAM output.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      aux_data_r  <= {DATA_WIDTH{1'b0}};
      aux_valid_r <= 1'b0;
    end else if (aux_tag_r[LATENCY-1]) begin
      aux_data_r  <= bus.mem_data_in;
      aux_valid_r <= 1'b1;
    end else begin
      aux_data_r  <= aux_data_r;
      aux_valid_r <= 1'b0;
    end
  end

  assign bus.aux_data_out  = aux_data_r;
  assign bus.aux_valid_out = aux_valid_r;

  // Wait counter: counts cycles a pending aux read is blocked by video;
  // saturates at the limit, which is all starve_out needs.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wait_cnt_r <= {WAIT_W{1'b0}};
    end else if (accept_s || issue_s) begin
      wait_cnt_r <= {WAIT_W{1'b0}};
    end else if (conflict_s && (wait_cnt_r < STARVE_LIMIT_C)) begin
      wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

  // Diagnostic only; video is never throttled by it.
  assign bus.starve_out = (wait_cnt_r >= STARVE_LIMIT_C);

`ifdef FB_ARB_STATS_EN
  logic [15:0] aux_grants_r;
  logic [15:0] vid_conflicts_r;

  // Saturating statistics counters, cleared only by reset
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      aux_grants_r    <= 16'h0000;
      vid_conflicts_r <= 16'h0000;
    end else begin
      if (issue_s && (aux_grants_r != 16'hFFFF)) begin
        aux_grants_r <= aux_grants_r + 16'd1;
      end else begin
        aux_grants_r <= aux_grants_r;
      end
      if (conflict_s && (vid_conflicts_r != 16'hFFFF)) begin
        vid_conflicts_r <= vid_conflicts_r + 16'd1;
      end else begin
        vid_conflicts_r <= vid_conflicts_r;
      end
    end
  end

  assign bus.aux_grants_out    = aux_grants_r;
  assign bus.vid_conflicts_out = vid_conflicts_r;
`else
  assign bus.aux_grants_out    = 16'h0000;
  assign bus.vid_conflicts_out = 16'h0000;
`endif

endmodule

// File: tb/tb_fb_read_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fb_read_arbiter
// Directed bench for fb_read_arbiter with a two-stage BRAM model whose data
// equals the low bits of the address. Inputs change 1 ns after the rising
// edge; outputs are sampled on the falling edge. Cycle numbers below are
// relative to the start of each scenario.
// -----------------------------------------------------------------------------
module tb_fb_read_arbiter;

  localparam int AW  = 17;
  localparam int DW  = 16;
  localparam int LAT = 2;
  localparam int SL  = 64;

`ifdef FB_ARB_STATS_EN
  localparam logic [31:0] EXP_GRANTS    = 32'd3;
  localparam logic [31:0] EXP_CONFLICTS = 32'd95;
`else
  localparam logic [31:0] EXP_GRANTS    = 32'd0;
  localparam logic [31:0] EXP_CONFLICTS = 32'd0;
`endif

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;

  always #8 clk_in = ~clk_in;

  fb_read_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  fb_read_arbiter #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .LATENCY     (LAT),
    .STARVE_LIMIT(SL)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .bus   (bus)
  );

  // BRAM model: two-cycle read latency, data = address[15:0]
  logic [DW-1:0] bram_d1_r = 16'h0000;
  logic [DW-1:0] bram_d2_r = 16'h0000;

  always @(posedge clk_in) begin
    bram_d1_r <= bus.mem_addr_out[DW-1:0];
    bram_d2_r <= bram_d1_r;
  end

  assign bus.mem_data_in = bram_d2_r;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h (t=%0t)",
               tag, obs, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_in);
    #1;
  endtask

  task automatic sample();
    @(negedge clk_in);
  endtask

  task automatic drive(input logic vreq, input logic [AW-1:0] vaddr,
                       input logic areq, input logic [AW-1:0] aaddr);
    bus.vid_req_in  = vreq;
    bus.vid_addr_in = vaddr;
    bus.aux_req_in  = areq;
    bus.aux_addr_in = aaddr;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_vid_valid"}, {31'd0, bus.vid_valid_out}, 32'd0);
    check_eq({tag, "_aux_valid"}, {31'd0, bus.aux_valid_out}, 32'd0);
    check_eq({tag, "_aux_ready"}, {31'd0, bus.aux_ready_out}, 32'd1);
    check_eq({tag, "_starve"},    {31'd0, bus.starve_out},    32'd0);
    check_eq({tag, "_aux_data"},  {16'd0, bus.aux_data_out},  32'd0);
    check_eq({tag, "_grants"},    {16'd0, bus.aux_grants_out},    32'd0);
    check_eq({tag, "_conflicts"}, {16'd0, bus.vid_conflicts_out}, 32'd0);
  endtask

  initial begin
    logic exp_v;

    // Power-on reset
    drive(1'b0, 17'h00000, 1'b0, 17'h00000);
    rst_in = 1'b0;
    sample();
    check_reset_outputs("por");
    check_eq("por_mem_addr", {15'd0, bus.mem_addr_out}, 32'd0);
    next_cycle();
    next_cycle();
    rst_in = 1'b1;
    for (int i = 0; i < 4; i++) next_cycle();

    // Video-only stream: addr 0..1023, returns two cycles later
    for (int t = 0; t < 1027; t++) begin
      drive(t < 1024, AW'(t), 1'b0, 17'h00000);
      sample();
      exp_v = (t >= 2) && (t <= 1025);
      check_eq("vs_vid_valid", {31'd0, bus.vid_valid_out}, {31'd0, exp_v});
      if (exp_v) check_eq("vs_vid_data", {16'd0, bus.vid_data_out}, 32'(t - 2));
      check_eq("vs_aux_valid", {31'd0, bus.aux_valid_out}, 32'd0);
      next_cycle();
    end

    // Aux read in blanking: accept t0, issue t1, valid t4
    for (int t = 0; t < 6; t++) begin
      drive(1'b0, 17'h00AAA, t == 0, 17'h01234);
      sample();
      check_eq("blank_aux_ready", {31'd0, bus.aux_ready_out}, {31'd0, (t != 1)});
      if (t == 1) check_eq("blank_mem_addr", {15'd0, bus.mem_addr_out}, 32'h1234);
      check_eq("blank_aux_valid", {31'd0, bus.aux_valid_out}, {31'd0, (t == 4)});
      if (t >= 4) check_eq("blank_aux_data", {16'd0, bus.aux_data_out}, 32'h1234);
      next_cycle();
    end

    // Aux blocked by video t0..t99, accepted t5, issued t100, valid t103
    for (int t = 0; t < 106; t++) begin
      drive(t < 100, (t < 100) ? AW'(32'h100 + t) : 17'h00555, t == 5, 17'h00777);
      sample();
      if (t < 100) check_eq("blk_mem_addr_vid", {15'd0, bus.mem_addr_out}, 32'h100 + t);
      if (t == 100) check_eq("blk_mem_addr_aux", {15'd0, bus.mem_addr_out}, 32'h777);
      exp_v = (t >= 2) && (t <= 101);
      check_eq("blk_vid_valid", {31'd0, bus.vid_valid_out}, {31'd0, exp_v});
      if (exp_v) check_eq("blk_vid_data", {16'd0, bus.vid_data_out}, 32'h100 + t - 2);
      check_eq("blk_aux_ready", {31'd0, bus.aux_ready_out}, {31'd0, (t <= 5) || (t >= 101)});
      check_eq("blk_starve", {31'd0, bus.starve_out}, {31'd0, (t >= 70) && (t <= 100)});
      check_eq("blk_aux_valid", {31'd0, bus.aux_valid_out}, {31'd0, (t == 103)});
      if (t == 103) check_eq("blk_aux_data", {16'd0, bus.aux_data_out}, 32'h777);
      next_cycle();
    end

    // One-cycle conflict: accept t0, video t1, issue t2, valid t5
    for (int t = 0; t < 7; t++) begin
      drive(t == 1, 17'h00300, t == 0, 17'h00042);
      sample();
      if (t == 1) check_eq("c1_mem_addr_vid", {15'd0, bus.mem_addr_out}, 32'h300);
      if (t == 2) check_eq("c1_mem_addr_aux", {15'd0, bus.mem_addr_out}, 32'h42);
      check_eq("c1_aux_ready", {31'd0, bus.aux_ready_out}, {31'd0, (t == 0) || (t >= 3)});
      check_eq("c1_vid_valid", {31'd0, bus.vid_valid_out}, {31'd0, (t == 3)});
      if (t == 3) check_eq("c1_vid_data", {16'd0, bus.vid_data_out}, 32'h300);
      check_eq("c1_aux_valid", {31'd0, bus.aux_valid_out}, {31'd0, (t == 5)});
      if (t == 5) check_eq("c1_aux_data", {16'd0, bus.aux_data_out}, 32'h42);
      next_cycle();
    end

    // Statistics after three issues and 94 + 1 conflict cycles
    sample();
    check_eq("stats_grants",    {16'd0, bus.aux_grants_out},    EXP_GRANTS);
    check_eq("stats_conflicts", {16'd0, bus.vid_conflicts_out}, EXP_CONFLICTS);
    next_cycle();

    // Reset mid-flight: video+accept t0, aux issue t1, reset from t2
    drive(1'b1, 17'h00010, 1'b1, 17'h00099);
    next_cycle();
    drive(1'b0, 17'h00010, 1'b0, 17'h00099);
    sample();
    check_eq("rst_issue_addr", {15'd0, bus.mem_addr_out}, 32'h99);
    next_cycle();
    rst_in = 1'b0;
    sample();
    check_reset_outputs("rst_mid");
    next_cycle();
    sample();
    check_reset_outputs("rst_hold");
    next_cycle();
    rst_in = 1'b1;
    for (int t = 0; t < 6; t++) begin
      sample();
      check_eq("post_rst_aux_valid", {31'd0, bus.aux_valid_out}, 32'd0);
      check_eq("post_rst_vid_valid", {31'd0, bus.vid_valid_out}, 32'd0);
      check_eq("post_rst_aux_ready", {31'd0, bus.aux_ready_out}, 32'd1);
      check_eq("post_rst_aux_data",  {16'd0, bus.aux_data_out},  32'd0);
      next_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
